// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root operand normaliser.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } sqrt_norm_state_e;

    // Operand width rounded up to a whole number of bit pairs.
    function automatic int even_width(input int w);
        return w + (w % 2);
    endfunction

    // Width of the pair-shift counter: enough for even_width(w)/2 - 1, at least 1.
    function automatic int shift_width(input int w);
        int half;
        half = even_width(w) / 2;
        return (half <= 1) ? 1 : $clog2(half);
    endfunction

endpackage

// File: rtl/sqrt_norm_uns.sv
// Operand normaliser for the unsigned restoring square-root array: shifts the
// operand left by bit pairs until the top pair is non-zero and reports the count.
module sqrt_norm_uns
    import sqrt_pkg::*;
#(
    parameter int WIDTH_X = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [WIDTH_X-1:0]                 x_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [even_width(WIDTH_X)-1:0]     xn_o,
    output logic [shift_width(WIDTH_X)-1:0]    shift_o,
    output logic                               zero_o
);

    localparam int WE = even_width(WIDTH_X);
    localparam int WS = shift_width(WIDTH_X);

    sqrt_norm_state_e r_state, w_state_nxt;
    logic [WE-1:0]    r_opnd;
    logic [WS-1:0]    r_cnt;
    logic             r_zero;

    logic [WE-1:0]    w_ext;
    logic [WE-1:0]    w_shifted;
    logic             w_accept;
    logic             w_ready;
    sqrt_norm_state_e w_load_state;

    assign w_ext     = WE'(x_i);
    assign w_shifted = r_opnd << 2;
    assign w_accept  = in_valid_i & w_ready;

    // A zero or already-normalised operand goes straight to HOLD.
    assign w_load_state = ((x_i == '0) || (w_ext[WE-1 -: 2] != 2'b00)) ? HOLD : SHIFT;

    // Next-state and handshake decode; ready is held low while reset is asserted.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (in_valid_i) w_state_nxt = w_load_state;
            end
            SHIFT: begin
                if (w_shifted[WE-1 -: 2] != 2'b00) w_state_nxt = HOLD;
            end
            HOLD: begin
                w_ready = out_ready_i;
                if (out_ready_i) w_state_nxt = in_valid_i ? w_load_state : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (rst_i) w_ready = 1'b0;
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Operand, pair count and zero flag: load on accept, shift one pair per SHIFT cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_opnd <= '0;
            r_cnt  <= '0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_opnd <= w_ext;
            r_cnt  <= '0;
            r_zero <= (x_i == '0);
        end else if (r_state == SHIFT) begin
            r_opnd <= w_shifted;
            r_cnt  <= r_cnt + WS'(1);
        end
    end

    assign in_ready_o  = w_ready;
    assign out_valid_o = (r_state == HOLD);
    assign xn_o        = r_opnd;
    assign shift_o     = r_cnt;
    assign zero_o      = r_zero;

endmodule

// File: tb/tb_sqrt_norm_uns.sv
// Self-checking bench for sqrt_norm_uns: directed cases plus a randomized run
// scored against a plain-arithmetic reference model.
module tb_sqrt_norm_uns;

    localparam int WE = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iv = 1'b0, ir, ov, ordy = 1'b0, zr;
    logic [7:0] x = '0, xn;
    logic [1:0] sh;

    logic       iv5 = 1'b0, ir5, ov5, ordy5 = 1'b0, zr5;
    logic [4:0] x5 = '0;
    logic [5:0] xn5;
    logic [1:0] sh5;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sqrt_norm_uns #(.WIDTH_X(8)) u8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv), .in_ready_o(ir), .x_i(x),
        .out_valid_o(ov), .out_ready_i(ordy), .xn_o(xn), .shift_o(sh), .zero_o(zr)
    );

    sqrt_norm_uns #(.WIDTH_X(5)) u5 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv5), .in_ready_o(ir5), .x_i(x5),
        .out_valid_o(ov5), .out_ready_i(ordy5), .xn_o(xn5), .shift_o(sh5), .zero_o(zr5)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: smallest pair shift putting a non-zero value's MSB in the top pair.
    function automatic void model(input int v, input int w, output int xn_m, output int k_m);
        k_m = 0;
        if (v != 0)
            while ((v << (2 * k_m)) < (1 << (w - 2))) k_m++;
        xn_m = v << (2 * k_m);
    endfunction

    function automatic int isqrt(input int v);
        int q = 0;
        while ((q + 1) * (q + 1) <= v) q++;
        return q;
    endfunction

    // One transaction on the 8-bit instance with the consumer always ready.
    task automatic run_one(input string tag, input logic [7:0] v, input int exp_lat,
                           input int exp_xn, input int exp_sh, input logic exp_z);
        int lat;
        @(negedge clk); iv = 1'b1; x = v; ordy = 1'b1;
        #1 chk({tag, "_rdy"}, 32'(ir), 32'd1);
        @(negedge clk); iv = 1'b0; x = 8'($urandom);
        lat = 1;
        while (!ov && lat < 20) begin
            chk({tag, "_busy"}, 32'(ir), 32'd0);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_xn"}, 32'(xn), 32'(exp_xn));
        chk({tag, "_sh"}, 32'(sh), 32'(exp_sh));
        chk({tag, "_z"}, 32'(zr), 32'(exp_z));
        @(negedge clk);
        chk({tag, "_pop"}, 32'(ov), 32'd0);
    endtask

    initial begin
        int lat, nval, sent, cyc, exp_xn, exp_k;
        int q[$];

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_ov", 32'(ov), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_xn", 32'(xn), 32'd0);
        chk("rst_sh", 32'(sh), 32'd0);
        chk("rst_z", 32'(zr), 32'd0);
        @(negedge clk); rst = 1'b0;
        #1 chk("rel_ir", 32'(ir), 32'd1);

        run_one("norm", 8'hC3, 1, 'hC3, 0, 1'b0);
        run_one("worst", 8'h01, 4, 'h40, 3, 1'b0);
        run_one("zero", 8'h00, 1, 0, 0, 1'b1);
        run_one("mid", 8'h07, 3, 'h70, 2, 1'b0);

        // Backpressure, then back-to-back accept in the releasing cycle
        @(negedge clk); iv = 1'b1; x = 8'h10; ordy = 1'b0;
        @(negedge clk); iv = 1'b0;
        lat = 1;
        while (!ov && lat < 20) begin @(negedge clk); lat++; end
        chk("bp_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_xn", 32'(xn), 32'h40);
            chk("bp_sh", 32'(sh), 32'd1);
            chk("bp_ir", 32'(ir), 32'd0);
            chk("bp_ov", 32'(ov), 32'd1);
            @(negedge clk);
        end
        iv = 1'b1; x = 8'h90; ordy = 1'b1;
        #1 chk("b2b_ir", 32'(ir), 32'd1);
        @(negedge clk); iv = 1'b0;
        chk("b2b_ov", 32'(ov), 32'd1);
        chk("b2b_xn", 32'(xn), 32'h90);
        chk("b2b_sh", 32'(sh), 32'd0);
        @(negedge clk);
        chk("b2b_pop", 32'(ov), 32'd0);

        // Odd width: 5-bit operand padded to 6 bits
        @(negedge clk); iv5 = 1'b1; x5 = 5'b00001; ordy5 = 1'b1;
        @(negedge clk); iv5 = 1'b0; x5 = 5'b11111;
        lat = 1;
        while (!ov5 && lat < 20) begin @(negedge clk); lat++; end
        chk("odd_lat", 32'(lat), 32'd3);
        chk("odd_xn", 32'(xn5), 32'b010000);
        chk("odd_sh", 32'(sh5), 32'd2);
        chk("odd_z", 32'(zr5), 32'd0);
        @(negedge clk);

        // Reset in the middle of SHIFT discards the operand
        @(negedge clk); iv = 1'b1; x = 8'h01; ordy = 1'b1;
        @(negedge clk); iv = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_ov", 32'(ov), 32'd0);
        chk("mrst_ir", 32'(ir), 32'd0);
        chk("mrst_xn", 32'(xn), 32'd0);
        @(negedge clk); rst = 1'b0;
        #1 chk("mrst_rel_ir", 32'(ir), 32'd1);
        nval = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ov) nval++;
        end
        chk("mrst_noout", 32'(nval), 32'd0);

        // Randomized traffic against the reference model
        sent = 0;
        cyc = 0;
        while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            iv   = (sent < 1000) && ($urandom_range(0, 3) != 0);
            x    = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            ordy = ($urandom_range(0, 2) != 0);
            #1;
            if (ov && ordy) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", 32'(ov), 32'd0);
                end else begin
                    int xv;
                    xv = q.pop_front();
                    model(xv, WE, exp_xn, exp_k);
                    chk("rnd_xn", 32'(xn), 32'(exp_xn));
                    chk("rnd_sh", 32'(sh), 32'(exp_k));
                    chk("rnd_z", 32'(zr), 32'(xv == 0));
                    chk("rnd_sqrt", 32'(isqrt(int'(xn)) >> sh), 32'(isqrt(xv)));
                end
            end
            if (iv && ir) begin
                q.push_back(int'(x));
                sent++;
            end
        end
        chk("rnd_done", 32'(q.size() == 0 && sent == 1000), 32'd1);
        iv = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
